// File: rtl/vm_pkg.sv
// Shared types and helpers for the N-candidate voting machine.
// Holds the controller state encoding and the lone-button detector.
package vm_pkg;

  localparam int MAX_CAND = 16;

  typedef enum logic [2:0] {
    LOCKED,
    ARMED,
    QUALIFY,
    RELEASE,
    SCAN,
    RESULT
  } vm_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot_t;

  // valid only when exactly one bit is set; idx is that bit's position
  function automatic onehot_t onehot_single(input logic [MAX_CAND-1:0] vec);
    onehot_t    res;
    logic [4:0] cnt;
    res.valid = 1'b0;
    res.idx   = '0;
    cnt       = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (vec[i]) begin
        cnt     = cnt + 5'd1;
        res.idx = 4'(i);
      end
    end
    res.valid = (cnt == 5'd1);
    return res;
  endfunction

endpackage

// File: rtl/vm_winner_scan.sv
// Sequential winner/tie scanner: walks the tally file one index per cycle.
// The lowest index wins ties; done is high during the last visit.
module vm_winner_scan
  import vm_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 2
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [CNT_W-1:0] rd_data,
  output logic [IDX_W-1:0] winner_idx,
  output logic             tie,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  logic             busy;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] best_q, best_n;
  logic [CNT_W-1:0] max_q, max_n;
  logic             tie_q, tie_n;
  logic             take;

  assign rd_idx = idx_q;
  assign done   = busy && (idx_q == LAST_IDX);

  // index 0 always seeds the running maximum
  always_comb begin
    take   = (idx_q == '0) || (rd_data > max_q);
    best_n = best_q;
    max_n  = max_q;
    tie_n  = tie_q;
    if (take) begin
      best_n = idx_q;
      max_n  = rd_data;
      tie_n  = 1'b0;
    end else if (rd_data == max_q) begin
      tie_n = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      busy       <= 1'b0;
      idx_q      <= '0;
      best_q     <= '0;
      max_q      <= '0;
      tie_q      <= 1'b0;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else if (abort) begin
      busy       <= 1'b0;
      idx_q      <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else if (start) begin
      busy       <= 1'b1;
      idx_q      <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else if (busy) begin
      best_q <= best_n;
      max_q  <= max_n;
      tie_q  <= tie_n;
      if (done) begin
        busy       <= 1'b0;
        winner_idx <= best_n;
        tie        <= tie_n;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voting_machine_nch.sv
// N-candidate voting machine: armed ballots, held-button qualification,
// saturating tallies and a result mode with winner scan and tally display.
//
// state   | meaning
// LOCKED  | no ballot open, buttons ignored
// ARMED   | ballot open, waiting for a lone button
// QUALIFY | lone button being timed by hold_cnt
// RELEASE | vote committed, waiting for all buttons low
// SCAN    | result mode, winner scan in progress
// RESULT  | result mode, winner outputs valid
module voting_machine_nch
  import vm_pkg::*;
#(
  parameter  int NUM_CAND    = 4,
  parameter  int CNT_W       = 8,
  parameter  int HOLD_CYCLES = 16,
  localparam int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] cand_button,
  input  logic [IDX_W-1:0]    sel_cand,
  output logic                vote_ack,
  output logic                armed,
  output logic [IDX_W-1:0]    winner_idx,
  output logic                winner_valid,
  output logic                tie,
  output logic                sat_flag,
  output logic [CNT_W-1:0]    LEDs
);

  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] TALLY_MAX = '1;

  vm_state_e           state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [IDX_W-1:0]    cap_idx, cap_n;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic                commit, scan_start, scan_abort, scan_done;
  logic [IDX_W-1:0]    scan_rd_idx;
  logic [CNT_W-1:0]    scan_rd_data;
  logic [NUM_CAND-1:0] cap_mask;
  logic                sel_ok;
  onehot_t             press;

  assign press    = onehot_single(MAX_CAND'(cand_button));
  assign cap_mask = NUM_CAND'(1) << cap_idx;
  assign sel_ok   = ({1'b0, sel_cand} < (IDX_W + 1)'(NUM_CAND));

  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    cap_n      = cap_idx;
    commit     = 1'b0;
    scan_start = 1'b0;
    scan_abort = 1'b0;
    case (state)
      LOCKED:  if (ballot_arm) state_n = ARMED;
      ARMED: begin
        if (press.valid) begin
          state_n = QUALIFY;
          cap_n   = IDX_W'(press.idx);
          hold_n  = HOLD_W'(1);
        end
      end
      QUALIFY: begin
        if (cand_button == cap_mask) begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES)) begin
            commit  = 1'b1;
            state_n = RELEASE;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end else begin
          state_n = ARMED;
          hold_n  = '0;
        end
      end
      RELEASE: if (cand_button == '0) state_n = LOCKED;
      SCAN: begin
        if (!mode) begin
          state_n    = LOCKED;
          scan_abort = 1'b1;
        end else if (scan_done) begin
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (!mode) begin
          state_n    = LOCKED;
          scan_abort = 1'b1;
        end
      end
      default: state_n = LOCKED;
    endcase
    // entering result mode cancels any open ballot, including a vote about to commit
    if (mode && state != SCAN && state != RESULT) begin
      state_n    = SCAN;
      hold_n     = '0;
      commit     = 1'b0;
      scan_start = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOCKED;
      hold_cnt <= '0;
      cap_idx  <= '0;
      vote_ack <= 1'b0;
      sat_flag <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      cap_idx  <= cap_n;
      vote_ack <= commit;
      if (commit) begin
        if (tally[cap_idx] == TALLY_MAX) sat_flag <= 1'b1;
        else tally[cap_idx] <= tally[cap_idx] + 1'b1;
      end
    end
  end

  assign scan_rd_data = tally[scan_rd_idx];

  vm_winner_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clk_sys    (clk),
    .rst_b      (reset),
    .start      (scan_start),
    .abort      (scan_abort),
    .rd_idx     (scan_rd_idx),
    .rd_data    (scan_rd_data),
    .winner_idx (winner_idx),
    .tie        (tie),
    .done       (scan_done)
  );

  assign armed        = (state == ARMED) || (state == QUALIFY);
  assign winner_valid = (state == RESULT);

  always_comb begin
    LEDs = '0;
    case (state)
      RESULT:  if (sel_ok) LEDs = tally[sel_cand];
      ARMED:   LEDs[0] = 1'b1;
      QUALIFY: LEDs[1] = 1'b1;
      RELEASE: LEDs[2] = 1'b1;
      default: LEDs = '0;
    endcase
  end

endmodule

// File: tb/tb_voting_machine_nch.sv
// Bench for voting_machine_nch: table vectors, directed corner sequences and
// randomized stimulus against a ballot-level reference model.
module tb_voting_machine_nch;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int HC = 4;
  localparam int IW = 2;
  localparam int TMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          ballot_arm;
  logic [NC-1:0] cand_button;
  logic [IW-1:0] sel_cand;
  logic          vote_ack, armed, winner_valid, tie, sat_flag;
  logic [IW-1:0] winner_idx;
  logic [CW-1:0] LEDs;

  voting_machine_nch #(.NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HC)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .ballot_arm   (ballot_arm),
    .cand_button  (cand_button),
    .sel_cand     (sel_cand),
    .vote_ack     (vote_ack),
    .armed        (armed),
    .winner_idx   (winner_idx),
    .winner_valid (winner_valid),
    .tie          (tie),
    .sat_flag     (sat_flag),
    .LEDs         (LEDs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ballot-level reference model
  int m_tally [NC];
  bit m_sat, m_open, m_wait, m_res, m_ack;
  int m_run, m_idx, m_cyc;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
    m_sat = 0; m_open = 0; m_wait = 0; m_res = 0; m_ack = 0;
    m_run = 0; m_idx = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    m_ack = 0;
    if (m_res) begin
      if (!mode) m_res = 0;
      else if (m_cyc < NC) m_cyc++;
    end else if (mode) begin
      m_res = 1; m_cyc = 0; m_open = 0; m_wait = 0; m_run = 0;
    end else if (m_wait) begin
      if (cand_button == '0) m_wait = 0;
    end else if (!m_open) begin
      if (ballot_arm) m_open = 1;
    end else if (m_run > 0) begin
      if (cand_button == (NC'(1) << m_idx)) begin
        if (m_run == HC) begin
          if (m_tally[m_idx] == TMAX) m_sat = 1;
          else m_tally[m_idx]++;
          m_ack = 1; m_open = 0; m_run = 0; m_wait = 1;
        end else m_run++;
      end else m_run = 0;
    end else if ($countones(cand_button) == 1) begin
      for (int i = 0; i < NC; i++) if (cand_button[i]) m_idx = i;
      m_run = 1;
    end
  endtask

  task automatic check_model();
    int w, mx, cnt;
    bit valid;
    logic [CW-1:0] eleds;
    valid = m_res && (m_cyc >= NC);
    mx = -1; w = 0; cnt = 0;
    for (int i = 0; i < NC; i++) if (m_tally[i] > mx) begin mx = m_tally[i]; w = i; end
    for (int i = 0; i < NC; i++) if (m_tally[i] == mx) cnt++;
    if (m_res) eleds = valid ? CW'(m_tally[sel_cand]) : '0;
    else eleds = CW'({m_wait, (m_run > 0), (m_open && m_run == 0)});
    chk("rnd vote_ack", vote_ack, m_ack);
    chk("rnd armed", armed, m_open);
    chk("rnd LEDs", LEDs, eleds);
    chk("rnd winner_valid", winner_valid, valid);
    chk("rnd winner_idx", winner_idx, valid ? w : 0);
    chk("rnd tie", tie, valid && cnt > 1);
    chk("rnd sat_flag", sat_flag, m_sat);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; mode = 1'b0; ballot_arm = 1'b0; cand_button = '0; sel_cand = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cast_vote(input int c, output bit ack);
    ballot_arm = 1'b1; cand_button = '0;
    cycle();
    ballot_arm = 1'b0; cand_button = NC'(1) << c;
    for (int i = 0; i < HC; i++) cycle();
    cycle();
    ack = vote_ack;
    cand_button = '0;
    cycle();
  endtask

  task automatic enter_result();
    mode = 1'b1;
    for (int i = 0; i <= NC; i++) begin
      cycle();
      chk($sformatf("scan wv step %0d", i), winner_valid, (i == NC));
    end
  endtask

  typedef struct packed {
    logic          arm;
    logic [NC-1:0] btn;
    logic          ack;
    logic          armd;
    logic [CW-1:0] leds;
  } vec_t;

  function automatic vec_t mk(logic a, logic [NC-1:0] b, logic k, logic m, logic [CW-1:0] l);
    vec_t v;
    v.arm = a; v.btn = b; v.ack = k; v.armd = m; v.leds = l;
    return v;
  endfunction

  vec_t tbl[$];
  bit   ack_b;
  int   acks;

  initial begin
    // arm, qualify cand1, re-press without re-arm
    tbl.push_back(mk(1, 4'b0000, 0, 1, 8'd1));
    for (int i = 0; i < HC; i++) tbl.push_back(mk(0, 4'b0010, 0, 1, 8'd2));
    tbl.push_back(mk(0, 4'b0010, 1, 0, 8'd4));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 8'd4));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 8'd0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 4'b0010, 0, 0, 8'd0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 8'd0));
    // short press on cand2 aborts, then cand0 qualifies; multi-press ignored
    tbl.push_back(mk(1, 4'b0000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 8'd2));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 8'd2));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 8'd1));
    for (int i = 0; i < HC; i++) tbl.push_back(mk(0, 4'b0001, 0, 1, 8'd2));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 8'd4));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 8'd0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 8'd1));
    tbl.push_back(mk(0, 4'b0011, 0, 1, 8'd1));
    tbl.push_back(mk(0, 4'b0011, 0, 1, 8'd1));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 8'd1));

    reset = 1'b0; mode = 1'b0; ballot_arm = 1'b0; cand_button = '0; sel_cand = '0;
    #1;
    chk("reset vote_ack", vote_ack, 0);
    chk("reset armed", armed, 0);
    chk("reset LEDs", LEDs, 0);
    chk("reset winner_valid", winner_valid, 0);
    chk("reset winner_idx", winner_idx, 0);
    chk("reset tie", tie, 0);
    chk("reset sat_flag", sat_flag, 0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      ballot_arm = tbl[i].arm; cand_button = tbl[i].btn;
      cycle();
      chk($sformatf("tbl[%0d] vote_ack", i), vote_ack, tbl[i].ack);
      chk($sformatf("tbl[%0d] armed", i), armed, tbl[i].armd);
      chk($sformatf("tbl[%0d] LEDs", i), LEDs, tbl[i].leds);
    end
    ballot_arm = 1'b0; cand_button = '0;
    enter_result();
    chk("tbl result winner_idx", winner_idx, 0);
    chk("tbl result tie", tie, 1);
    sel_cand = 2'd1; #1 chk("tbl tally1", LEDs, 1);
    sel_cand = 2'd2; #1 chk("tbl tally2", LEDs, 0);
    mode = 1'b0;
    cycle();
    chk("tbl exit wv", winner_valid, 0);

    // votes 3/5/5/1
    do_reset();
    for (int c = 0; c < NC; c++) begin
      int n;
      n = (c == 0) ? 3 : (c == 3) ? 1 : 5;
      for (int k = 0; k < n; k++) cast_vote(c, ack_b);
    end
    enter_result();
    chk("vote3551 winner_idx", winner_idx, 1);
    chk("vote3551 tie", tie, 1);
    sel_cand = 2'd2; #1 chk("vote3551 tally2", LEDs, 5);
    sel_cand = 2'd3; #1 chk("vote3551 tally3", LEDs, 1);
    sel_cand = 2'd0; #1 chk("vote3551 tally0", LEDs, 3);

    // saturation on cand3
    do_reset();
    acks = 0;
    for (int v = 1; v <= TMAX + 1; v++) begin
      cast_vote(3, ack_b);
      if (ack_b) acks++;
      if (v == TMAX) chk("sat before 256th", sat_flag, 0);
      if (v == TMAX + 1) begin
        chk("ack on 256th", ack_b, 1);
        chk("sat after 256th", sat_flag, 1);
      end
    end
    chk("sat ack count", acks, TMAX + 1);
    enter_result();
    sel_cand = 2'd3; #1 chk("sat tally3", LEDs, TMAX);
    chk("sat winner_idx", winner_idx, 3);
    chk("sat tie", tie, 0);
    mode = 1'b0;
    cycle();

    // result mode entered mid-qualify
    do_reset();
    cast_vote(2, ack_b);
    ballot_arm = 1'b1; cycle();
    ballot_arm = 1'b0; cand_button = 4'b0001;
    repeat (3) cycle();
    mode = 1'b1;
    cycle();
    chk("midq ack", vote_ack, 0);
    chk("midq LEDs scan", LEDs, 0);
    chk("midq armed", armed, 0);
    cycle();
    mode = 1'b0;
    cycle();
    chk("midq abort wv", winner_valid, 0);
    chk("midq abort LEDs", LEDs, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("midq cancelled ack", vote_ack, 0);
    end
    cand_button = '0;
    enter_result();
    chk("midq winner_idx", winner_idx, 2);
    sel_cand = 2'd0; #1 chk("midq tally0", LEDs, 0);
    mode = 1'b0;
    cycle();

    // async reset in QUALIFY and in RESULT
    do_reset();
    cast_vote(1, ack_b);
    ballot_arm = 1'b1; cycle();
    ballot_arm = 1'b0; cand_button = 4'b0010;
    repeat (2) cycle();
    #2 reset = 1'b0;
    #1;
    chk("rstq armed", armed, 0);
    chk("rstq LEDs", LEDs, 0);
    chk("rstq ack", vote_ack, 0);
    model_reset();
    cand_button = '0;
    @(negedge clk) reset = 1'b1;
    enter_result();
    chk("rstq winner_idx", winner_idx, 0);
    chk("rstq tie", tie, 1);
    sel_cand = 2'd1; #1 chk("rstq tally1", LEDs, 0);
    mode = 1'b0;
    cycle();
    cast_vote(2, ack_b);
    cast_vote(2, ack_b);
    enter_result();
    sel_cand = 2'd2; #1 chk("rstr tally2", LEDs, 2);
    #2 reset = 1'b0;
    #1;
    chk("rstr LEDs", LEDs, 0);
    chk("rstr wv", winner_valid, 0);
    chk("rstr winner_idx", winner_idx, 0);
    chk("rstr tie", tie, 0);
    model_reset();
    mode = 1'b0;
    @(negedge clk) reset = 1'b1;

    // randomized run against the model
    do_reset();
    for (int s = 0; s < 500; s++) begin
      int len, r;
      len = $urandom_range(1, 7);
      r   = $urandom_range(0, 9);
      if (r < 6) cand_button = NC'(1) << $urandom_range(0, NC - 1);
      else if (r < 8) cand_button = '0;
      else cand_button = NC'($urandom);
      ballot_arm = ($urandom_range(0, 3) == 0);
      if (mode) mode = ($urandom_range(0, 2) != 0);
      else mode = ($urandom_range(0, 14) == 0);
      sel_cand = IW'($urandom);
      for (int c = 0; c < len; c++) begin
        cycle();
        check_model();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voting_machine_nch.md
Name: voting_machine_nch

Overview:
- Parametrised N-candidate successor of the 4-candidate voting machine.
- Per-ballot presiding-officer arming, one-vote-per-ballot lockout, button hold qualification, saturating per-candidate tallies.
- Result mode runs a sequential winner/tie scan and displays any selected candidate's tally.
- Top level of the voting datapath; drives board LEDs directly.

Parameters:
- NUM_CAND, 4: candidate count, 2..16.
- CNT_W, 8: tally width per candidate; also the LEDs width.
- HOLD_CYCLES, 16: consecutive cycles a lone button must be held for a vote to qualify; must be >= 1.
- IDX_W, $clog2(NUM_CAND): candidate index width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = voting, 1 = result.
- ballot_arm  in  1  officer enables one ballot; level or pulse; sampled only in LOCKED.
- cand_button  in  NUM_CAND  synchronised candidate buttons, bit i = candidate i.
- sel_cand  in  IDX_W  candidate whose tally is shown in result mode.
- vote_ack  out  1  one-cycle pulse when a vote is committed.
- armed  out  1  high while a ballot is open (ARMED, QUALIFY).
- winner_idx  out  IDX_W  index of the highest tally.
- winner_valid  out  1  scan complete, results stable.
- tie  out  1  maximum tally shared by two or more candidates.
- sat_flag  out  1  sticky; some tally has saturated.
- LEDs  out  CNT_W  display output.

Behaviour:
- Reset (async assert, sync deassert on board): state LOCKED, all tallies 0, hold counter 0, vote_ack 0, winner_idx 0, winner_valid 0, tie 0, sat_flag 0, LEDs 0.
- FSM states: LOCKED, ARMED, QUALIFY, RELEASE, SCAN, RESULT.
- Voting-mode transitions (mode=0):
  - LOCKED: ballot_arm=1 -> ARMED. Buttons are ignored in LOCKED.
  - ARMED: exactly one bit of cand_button high -> QUALIFY; capture that index; hold counter = 1. Zero or multiple bits high -> stay ARMED.
  - QUALIFY, same lone bit still high:
    - hold < HOLD_CYCLES -> hold counter increments.
    - hold = HOLD_CYCLES -> commit: tally[idx] += 1, vote_ack=1 for exactly one cycle, -> RELEASE.
  - QUALIFY, captured bit drops or any other bit rises -> ARMED, no commit. The ballot stays open.
  - RELEASE: all buttons low -> LOCKED. ballot_arm is ignored here. A second vote per ballot is impossible.
- Latency: commit occurs HOLD_CYCLES cycles after the ARMED->QUALIFY edge. vote_ack is registered and aligned with the tally update.
- Saturation: a tally already at 2^CNT_W-1 does not wrap. vote_ack still pulses. sat_flag is set and stays set until reset.
- Mode transitions:
  - mode 0->1 from any voting state -> SCAN. An in-flight QUALIFY is discarded and the open ballot is cancelled. Tallies are frozen.
  - SCAN: visit index 0..NUM_CAND-1, one per cycle, with a registered running max.
    - Strictly greater tally -> new max; clear tie.
    - Equal tally -> set tie; winner stays at the lower index.
    - After NUM_CAND cycles -> RESULT: winner_valid=1; winner_idx and tie are updated.
  - RESULT: hold outputs.
  - mode 1->0 in SCAN or RESULT -> LOCKED next cycle. winner_valid, winner_idx and tie clear to 0.
  - All tallies 0 gives winner_idx=0, tie=1 (when NUM_CAND>1).
- LEDs:
  - RESULT: tally[sel_cand]; sel_cand >= NUM_CAND shows 0.
  - SCAN: 0.
  - Voting mode: bit0 = ARMED, bit1 = QUALIFY, bit2 = RELEASE, other bits 0.
- Reset asserted mid-ballot or mid-scan: immediate return to reset values.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (LOCKED, ARMED, QUALIFY, RELEASE, SCAN, RESULT)
  - function onehot_single(vec) -> {valid, idx}
  - constant MAX_CAND = 16
- Sub-module vm_winner_scan: sequential max/tie scanner with ports start, abort, tally read index/data, winner_idx, tie, done.
- FSM, hold counter and tally register file stay in the top module.

Test Plan (NUM_CAND=4, CNT_W=8, HOLD_CYCLES=4):
- Arm, hold cand_button=4'b0010 for 4 cycles, release -> one vote_ack pulse, tally[1]=1. Second press without re-arm -> no ack, tally[1] stays 1.
- Arm, hold 4'b0100 for 2 cycles, release, then hold 4'b0001 for 4 cycles -> no commit for cand2; tally[0]=1. Pressing 4'b0011 while ARMED -> stays ARMED, no ack.
- Votes 3/5/5/1 then mode=1 -> winner_valid after 4 SCAN cycles, winner_idx=1, tie=1. sel_cand=2 -> LEDs=8'd5; sel_cand=3 -> LEDs=8'd1.
- 256 qualified votes for cand3 -> tally[3]=255, sat_flag=1 from the 256th vote, vote_ack still pulses.
- mode=1 at hold cycle 3 of QUALIFY -> no commit, SCAN starts. mode=0 during SCAN -> LOCKED, winner_valid=0.
- Assert reset while in QUALIFY and while in RESULT with non-zero tallies -> all outputs and tallies 0 asynchronously, state LOCKED.
